// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states
// and op-class helpers.
package muldiv_pkg;

    localparam logic [4:0] SEL_MUL    = 5'b01011;
    localparam logic [4:0] SEL_MULH   = 5'b01100;
    localparam logic [4:0] SEL_MULHSU = 5'b01101;
    localparam logic [4:0] SEL_MULHU  = 5'b01110;
    localparam logic [4:0] SEL_DIV    = 5'b01111;
    localparam logic [4:0] SEL_DIVU   = 5'b10000;
    localparam logic [4:0] SEL_REM    = 5'b10001;
    localparam logic [4:0] SEL_REMU   = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic is_mul(input logic [4:0] sel);
        return (sel == SEL_MUL) || (sel == SEL_MULH) || (sel == SEL_MULHSU) || (sel == SEL_MULHU);
    endfunction

    function automatic logic is_div(input logic [4:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_DIVU) || (sel == SEL_REM) || (sel == SEL_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [4:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_REM);
    endfunction

    function automatic logic is_rem(input logic [4:0] sel);
        return (sel == SEL_REM) || (sel == SEL_REMU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      select;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, select, data1, data2, flush, input busy, done, result);
    modport slave  (input start, select, data1, data2, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so XLEN bits complete XLEN edges after start.
module serial_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]   quo_r, rem_r, dvsr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r, done_r;
    logic [2*XLEN-1:0] first_s, next_s;

    // One restoring step; returns {remainder, quotient}. Partial remainder stays below the divisor.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvsr);
        logic [XLEN:0] shifted;
        logic [XLEN:0] diff;
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dvsr};
        if (diff[XLEN]) begin
            return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
        end else begin
            return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
        end
    endfunction

    // Step candidates for the start edge and for each running iteration
    always_comb begin
        first_s = div_step({XLEN{1'b0}}, dividend, divisor);
        next_s  = div_step(rem_r, quo_r, dvsr_r);
    end

    // Iteration state, counter and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_r  <= {XLEN{1'b0}};
            rem_r  <= {XLEN{1'b0}};
            dvsr_r <= {XLEN{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (abort) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            {rem_r, quo_r} <= first_s;
            dvsr_r <= divisor;
            cnt_r  <= CNT_W'(XLEN - 1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            {rem_r, quo_r} <= next_s;
            cnt_r  <= cnt_r - CNT_W'(1);
            busy_r <= (cnt_r != CNT_W'(1));
            done_r <= (cnt_r == CNT_W'(1));
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execution unit: pipelined multiply, iterative divide,
// control FSM with stall (busy), completion pulse (done) and flush.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int              PIPE_DEPTH   = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
    localparam logic [1:0]      MUL_CNT_INIT = (MUL_LATENCY > 1) ? 2'(MUL_LATENCY - 2) : 2'd0;
    localparam logic [XLEN-1:0] ZERO         = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG     = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_r, state_nx_s;
    logic [4:0]        sel_r;
    logic              q_neg_r, r_neg_r;
    logic [1:0]        mul_cnt_r;
    logic [2*XLEN-1:0] mul_pipe_r [PIPE_DEPTH];
    logic [XLEN-1:0]   result_r, result_nx_s;
    logic              busy_r, done_r;

    logic              is_mul_s, is_div_s, accept_s, sgn_div_s, rem_op_s, special_s;
    logic              a_neg_s, b_neg_s, div_start_s, div_busy_s, div_done_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, special_res_s, mul_res_s, div_res_s, quo_s, rem_s;
    logic [2*XLEN-1:0] ext_a_s, ext_b_s, prod_s, mul_tap_s;

    // Request decode, operand magnitudes and special-case divide results
    always_comb begin
        is_mul_s  = is_mul(bus.select);
        is_div_s  = is_div(bus.select);
        accept_s  = bus.start & ~bus.flush & ((state_r == ST_IDLE) | (state_r == ST_FIN))
                    & (is_mul_s | is_div_s);
        sgn_div_s = is_signed_div(bus.select);
        rem_op_s  = is_rem(bus.select);
        a_neg_s   = sgn_div_s & bus.data1[XLEN-1];
        b_neg_s   = sgn_div_s & bus.data2[XLEN-1];
        mag_a_s   = a_neg_s ? (ZERO - bus.data1) : bus.data1;
        mag_b_s   = b_neg_s ? (ZERO - bus.data2) : bus.data2;
        if (bus.data2 == ZERO) begin
            special_s     = 1'b1;
            special_res_s = rem_op_s ? bus.data1 : ALL_ONES;
        end else if (sgn_div_s && (bus.data1 == MOST_NEG) && (bus.data2 == ALL_ONES)) begin
            special_s     = 1'b1;
            special_res_s = rem_op_s ? ZERO : bus.data1;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO;
        end
        div_start_s = accept_s & is_div_s & ~special_s;
    end

    // Full-width product with per-op sign extension; result half picked on exit
    always_comb begin
        ext_a_s = ((bus.select == SEL_MULH) || (bus.select == SEL_MULHSU))
                  ? {{XLEN{bus.data1[XLEN-1]}}, bus.data1} : {{XLEN{1'b0}}, bus.data1};
        ext_b_s = (bus.select == SEL_MULH)
                  ? {{XLEN{bus.data2[XLEN-1]}}, bus.data2} : {{XLEN{1'b0}}, bus.data2};
        prod_s    = ext_a_s * ext_b_s;
        mul_tap_s = (MUL_LATENCY > 1) ? mul_pipe_r[PIPE_DEPTH-1] : prod_s;
        if (((MUL_LATENCY > 1) ? sel_r : bus.select) == SEL_MUL) begin
            mul_res_s = mul_tap_s[XLEN-1:0];
        end else begin
            mul_res_s = mul_tap_s[2*XLEN-1:XLEN];
        end
        if (is_rem(sel_r)) begin
            div_res_s = r_neg_r ? (ZERO - rem_s) : rem_s;
        end else begin
            div_res_s = q_neg_r ? (ZERO - quo_s) : quo_s;
        end
    end

    // Control FSM next state and result capture; FIN accepts like IDLE for back-to-back issue
    always_comb begin
        state_nx_s  = state_r;
        result_nx_s = result_r;
        if (bus.flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_FIN: begin
                    if (accept_s && is_mul_s) begin
                        if (MUL_LATENCY > 1) begin
                            state_nx_s = ST_MUL;
                        end else begin
                            state_nx_s  = ST_FIN;
                            result_nx_s = mul_res_s;
                        end
                    end else if (accept_s && special_s) begin
                        state_nx_s  = ST_FIN;
                        result_nx_s = special_res_s;
                    end else if (accept_s) begin
                        state_nx_s = ST_DIV;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_cnt_r == 2'd0) begin
                        state_nx_s  = ST_FIN;
                        result_nx_s = mul_res_s;
                    end else begin
                        state_nx_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (div_done_s && !div_busy_s) begin
                        state_nx_s  = ST_FIN;
                        result_nx_s = div_res_s;
                    end else begin
                        state_nx_s = ST_DIV;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, result and status flags; busy/done are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            result_r <= ZERO;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            result_r <= result_nx_s;
            busy_r   <= (state_nx_s == ST_MUL) || (state_nx_s == ST_DIV);
            done_r   <= (state_nx_s == ST_FIN);
        end
    end

    // Operand latch: op code, result signs and multiply latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= 5'd0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            mul_cnt_r <= 2'd0;
        end else if (accept_s) begin
            sel_r     <= bus.select;
            q_neg_r   <= a_neg_s ^ b_neg_s;
            r_neg_r   <= a_neg_s;
            mul_cnt_r <= MUL_CNT_INIT;
        end else if ((state_r == ST_MUL) && (mul_cnt_r != 2'd0)) begin
            mul_cnt_r <= mul_cnt_r - 2'd1;
        end
    end

    // Multiply pipeline shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) mul_pipe_r[i] <= {(2*XLEN){1'b0}};
        end else begin
            if (accept_s && is_mul_s) mul_pipe_r[0] <= prod_s;
            for (int i = 1; i < PIPE_DEPTH; i++) mul_pipe_r[i] <= mul_pipe_r[i-1];
        end
    end

    serial_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_s),
        .abort     (bus.flush),
        .dividend  (mag_a_s),
        .divisor   (mag_b_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (quo_s),
        .remainder (rem_s)
    );

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected result, DONE
// cycle and busy-cycle total; a negedge monitor pops and compares on DONE.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        int          busy;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0, busy_total = 0, done_count = 0;
    int   checks = 0, errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: cycle/busy bookkeeping and scoreboard compare on every DONE
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (bus.busy) busy_total = busy_total + 1;
        if (bus.done) begin
            done_count = done_count + 1;
            check("done_busy_excl", {31'd0, bus.busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_result"}, bus.result, e.val);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_busycnt"}, 32'(busy_total), 32'(e.busy));
            end
        end
    end

    // Drive one request for one edge, then scramble operands; ends #1 after a negedge
    task automatic drive(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.select = sel;
        bus.data1  = a;
        bus.data2  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.data1 = 32'hDEAD_BEEF;
        bus.data2 = 32'h0BAD_F00D;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] val, input int lat, input int nbusy, input string nm);
        exp_t e;
        e.val  = val;
        e.cyc  = cyc + lat;
        e.busy = busy_total + nbusy;
        e.name = nm;
        exp_q.push_back(e);
        drive(sel, a, b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 100)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] val, input int lat, input int nbusy, input string nm);
        issue(sel, a, b, val, lat, nbusy, nm);
        wait_idle();
    endtask

    initial begin
        int d0;
        bus.start  = 1'b0;
        bus.select = 5'd0;
        bus.data1  = 32'd0;
        bus.data2  = 32'd0;
        bus.flush  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        run(SEL_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1, "mul");
        run(SEL_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 1, "mulh");
        run(SEL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1, "mulhu");
        run(SEL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1, "mulhsu");

        run(SEL_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, "div_neg");
        run(SEL_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32, "rem_neg");
        run(SEL_DIVU, 32'd100, 32'd7, 32'd14, 33, 32, "divu");
        run(SEL_REMU, 32'd100, 32'd7, 32'd2, 33, 32, "remu");

        run(SEL_DIV,  32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_by0");
        run(SEL_REM,  32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0, "rem_by0");
        run(SEL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        run(SEL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, "rem_ovf");
        run(SEL_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
        run(SEL_REMU, 32'd5, 32'd0, 32'd5, 1, 0, "remu_by0");

        // Non-M select is ignored
        d0 = done_count;
        drive(5'b00000, 32'd1, 32'd2);
        check("nonm_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("nonm_no_done", 32'(done_count), 32'(d0));

        // Flush mid-divide: no DONE, result kept, next MUL completes
        d0 = done_count;
        drive(SEL_DIV, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        #1;
        check("flush_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        #1;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_done", {31'd0, bus.done}, 32'd0);
        check("flush_result", bus.result, 32'd5);
        repeat (40) @(negedge clk);
        #1;
        check("flush_no_done", 32'(done_count), 32'(d0));
        run(SEL_MUL, 32'd6, 32'd7, 32'd42, 2, 1, "mul_after_flush");

        // Flush coincident with START drops the request
        d0 = done_count;
        bus.flush = 1'b1;
        drive(SEL_MUL, 32'd3, 32'd3);
        bus.flush = 1'b0;
        check("flush_start_busy", {31'd0, bus.busy}, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("flush_start_no_done", 32'(done_count), 32'(d0));

        // START while busy is ignored
        issue(SEL_DIVU, 32'd1000, 32'd10, 32'd100, 33, 32, "divu_busy_start");
        repeat (3) @(negedge clk);
        #1;
        drive(SEL_MUL, 32'd3, 32'd3);
        wait_idle();

        // Back-to-back issue in the DONE cycle
        issue(SEL_MUL, 32'd5, 32'd6, 32'd30, 2, 1, "b2b_mul");
        @(negedge clk);
        #1;
        check("b2b_done_visible", {31'd0, bus.done}, 32'd1);
        issue(SEL_MULHU, 32'h8000_0000, 32'd4, 32'd2, 2, 1, "b2b_mulhu");
        @(negedge clk);
        #1;
        issue(SEL_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0, "b2b_div0");
        issue(SEL_REM, 32'd9, 32'd0, 32'd9, 1, 0, "b2b_rem0");
        wait_idle();

        // Asynchronous reset mid-divide
        d0 = done_count;
        drive(SEL_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(negedge clk);
        #1;
        check("rst_busy_before", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("rst_no_done", 32'(done_count), 32'(d0));
        run(SEL_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 2, 1, "mul_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
